// File: rtl/code_nco_ctrl.sv
// Code NCO control: chip-rate word shadowing, half-chip gating,
// epoch tracking and epoch-aligned code phase slewing.
module code_nco_ctrl #(
  parameter logic [27:0] FREQ_RST     = 28'h1A30552,
  parameter int          HC_PER_EPOCH = 2046
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_freq,
  input  logic [27:0] freq_data,
  input  logic        wr_slew,
  input  logic [10:0] slew_data,
  input  logic        hc_enable_in,
  output logic [27:0] f_control,
  output logic        hc_gated,
  output logic [10:0] hc_count,
  output logic        epoch,
  output logic        slew_busy,
  output logic        slew_done
);

  localparam logic [10:0] HC_LAST = 11'(HC_PER_EPOCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SLEWING
  } state_t;

  state_t      state_q;
  logic        hc_gated_q;
  logic [10:0] hc_cnt_q;
  logic [10:0] hc_cnt_d;
  logic        epoch_q;
  logic        epoch_d;
  logic        done_q;
  logic [10:0] pend_q;
  logic [10:0] slew_q;
  logic [27:0] shadow_q;
  logic [27:0] fctl_q;
  logic        slew_ok;

  assign slew_ok = wr_slew && (slew_data != 11'd0);

  // Phase counter advances on each passed half-chip, wrapping at epoch end.
  always_comb begin
    epoch_d  = hc_gated_q && (hc_cnt_q == HC_LAST);
    hc_cnt_d = hc_cnt_q;
    if (hc_gated_q)
      hc_cnt_d = epoch_d ? 11'd0 : hc_cnt_q + 11'd1;
  end

  // Gated half-chip, phase counter and epoch pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_gated_q <= 1'b0;
      hc_cnt_q   <= '0;
      epoch_q    <= 1'b0;
    end else begin
      hc_gated_q <= hc_enable_in && (state_q != SLEWING);
      hc_cnt_q   <= hc_cnt_d;
      epoch_q    <= epoch_d;
    end
  end

  // Frequency word is staged in a shadow and applied just after epoch.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= FREQ_RST;
      fctl_q   <= FREQ_RST;
    end else begin
      if (wr_freq)
        shadow_q <= freq_data;
      if (epoch_q)
        fctl_q <= wr_freq ? freq_data : shadow_q;
    end
  end

  // Slew FSM: arm on write, start at epoch, swallow N half-chips.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      slew_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (slew_ok) begin
            pend_q  <= slew_data;
            state_q <= PENDING;
          end
        end
        PENDING: begin
          if (epoch_q) begin
            slew_q  <= slew_ok ? slew_data : pend_q;
            state_q <= SLEWING;
          end else if (slew_ok) begin
            pend_q <= slew_data;
          end
        end
        SLEWING: begin
          if (hc_enable_in) begin
            slew_q <= slew_q - 11'd1;
            if (slew_q == 11'd1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f_control = fctl_q;
  assign hc_gated  = hc_gated_q;
  assign hc_count  = hc_cnt_q;
  assign epoch     = epoch_q;
  assign slew_busy = (state_q != IDLE);
  assign slew_done = done_q;

endmodule

// File: tb/tb_code_nco_ctrl.sv
// Bench for code_nco_ctrl: directed scenarios plus random traffic
// compared cycle by cycle with a behavioural model.
module tb_code_nco_ctrl;

  localparam int          HC   = 20;
  localparam logic [27:0] FRST = 28'h1A30552;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_freq;
  logic [27:0] freq_data;
  logic        wr_slew;
  logic [10:0] slew_data;
  logic        hc_enable_in;
  logic [27:0] f_control;
  logic        hc_gated;
  logic [10:0] hc_count;
  logic        epoch;
  logic        slew_busy;
  logic        slew_done;

  code_nco_ctrl #(.FREQ_RST(FRST), .HC_PER_EPOCH(HC)) dut (
    .clk(clk), .rst(rst),
    .wr_freq(wr_freq), .freq_data(freq_data),
    .wr_slew(wr_slew), .slew_data(slew_data),
    .hc_enable_in(hc_enable_in),
    .f_control(f_control), .hc_gated(hc_gated),
    .hc_count(hc_count), .epoch(epoch),
    .slew_busy(slew_busy), .slew_done(slew_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model: mode 0 idle, 1 armed, 2 swallowing
  int          m_mode, m_total, m_pend, m_left, m_sup, m_dones;
  bit          m_gated, m_epoch, m_done;
  logic [27:0] m_f, m_shadow;

  task automatic chk(input string tag, input logic [27:0] obs,
                     input logic [27:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_total = 0; m_pend = 0; m_left = 0;
    m_gated = 0; m_epoch = 0; m_done = 0;
    m_f = FRST; m_shadow = FRST;
  endtask

  task automatic step(input bit hc, input bit wf, input logic [27:0] fd,
                      input bit ws, input logic [10:0] sd, input bit r);
    bit ng, ne;
    rst = r; hc_enable_in = hc; wr_freq = wf; freq_data = fd;
    wr_slew = ws; slew_data = sd;
    @(posedge clk);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      ng = hc && (m_mode != 2);
      ne = 0;
      if (m_gated) begin
        m_total++;
        ne = (m_total % HC) == 0;
      end
      if (m_epoch) m_f = wf ? fd : m_shadow;
      if (wf) m_shadow = fd;
      m_done = 0;
      if (m_mode == 0) begin
        if (ws && sd != 0) begin m_mode = 1; m_pend = sd; end
      end else if (m_mode == 1) begin
        if (m_epoch) begin
          m_mode = 2; m_left = (ws && sd != 0) ? int'(sd) : m_pend;
        end else if (ws && sd != 0) m_pend = sd;
      end else if (hc) begin
        m_left--; m_sup++;
        if (m_left == 0) begin m_mode = 0; m_done = 1; m_dones++; end
      end
      m_gated = ng; m_epoch = ne;
    end
    #1;
    chk("hc_gated", 28'(hc_gated), 28'(m_gated));
    chk("hc_count", 28'(hc_count), 28'(m_total % HC));
    chk("epoch", 28'(epoch), 28'(m_epoch));
    chk("slew_busy", 28'(slew_busy), 28'(m_mode != 0));
    chk("slew_done", 28'(slew_done), 28'(m_done));
    chk("f_control", f_control, m_f);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      step((cyc % 3) == 0, 0, 28'h0, 0, 11'h0, 0);
  endtask

  task automatic wait_ep(input string tag);
    int k;
    k = 0;
    while (!m_epoch && k < 2000) begin
      step((cyc % 3) == 0, 0, 28'h0, 0, 11'h0, 0);
      k++;
    end
    if (!m_epoch) chk({tag, "_timeout"}, 28'd0, 28'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (m_mode != 0 && k < 3000) begin
      step((cyc % 3) == 0, 0, 28'h0, 0, 11'h0, 0);
      k++;
    end
    if (m_mode != 0) chk({tag, "_timeout"}, 28'd0, 28'd1);
  endtask

  initial begin
    m_sup = 0; m_dones = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 28'h0, 0, 11'h0, 1);
    chk("rst_f_control", f_control, FRST);
    chk("rst_hc_count", 28'(hc_count), 28'd0);

    // free running across two epoch wraps
    run(2 * 3 * HC + 5);

    // zero slew is ignored
    step(0, 0, 28'h0, 1, 11'd0, 0);
    chk("slew0_busy", 28'(slew_busy), 28'd0);

    // slew of 5 mid-epoch
    run(7);
    m_sup = 0;
    step(0, 0, 28'h0, 1, 11'd5, 0);
    chk("slew5_busy", 28'(slew_busy), 28'd1);
    wait_ep("slew5_ep");
    wait_idle("slew5");
    chk("slew5_suppressed", 28'(m_sup), 28'd5);
    run(40);

    // frequency write mid-epoch applied after next epoch
    run(10);
    step(0, 1, 28'h1A30600, 0, 11'h0, 0);
    chk("freq_hold", f_control, FRST);
    wait_ep("freq_ep");
    step(0, 0, 28'h0, 0, 11'h0, 0);
    chk("freq_applied", f_control, 28'h1A30600);

    // write coinciding with epoch bypasses the shadow
    wait_ep("byp_ep");
    step(0, 1, 28'h0ABCDEF, 0, 11'h0, 0);
    chk("freq_bypass", f_control, 28'h0ABCDEF);

    // two writes in one epoch: last wins
    run(5);
    step(0, 1, 28'h1111111, 0, 11'h0, 0);
    run(4);
    step(0, 1, 28'h2222222, 0, 11'h0, 0);
    wait_ep("last_ep");
    step(0, 0, 28'h0, 0, 11'h0, 0);
    chk("freq_last", f_control, 28'h2222222);

    // 3 then 7 while armed; a write while swallowing is ignored
    run(4);
    m_sup = 0;
    step(0, 0, 28'h0, 1, 11'd3, 0);
    run(3);
    step(0, 0, 28'h0, 1, 11'd7, 0);
    wait_ep("s7_ep");
    run(4);
    step(0, 0, 28'h0, 1, 11'd2, 0);
    wait_idle("s7");
    chk("slew7_suppressed", 28'(m_sup), 28'd7);

    // slew write on the epoch cycle waits for the following epoch
    wait_ep("coin_ep");
    step(0, 0, 28'h0, 1, 11'd4, 0);
    run(6);
    chk("coin_still_armed", 28'(slew_busy), 28'd1);
    wait_idle("coin");

    // reset during slewing aborts with no done pulse
    step(0, 1, 28'h0123456, 1, 11'd30, 0);
    wait_ep("abort_ep");
    run(9);
    step(0, 0, 28'h0, 0, 11'h0, 1);
    chk("abort_busy", 28'(slew_busy), 28'd0);
    chk("abort_done", 28'(slew_done), 28'd0);
    chk("abort_f", f_control, FRST);
    run(3 * HC + 5);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      bit hc, wf, ws, r;
      logic [27:0] fd;
      logic [10:0] sd;
      hc = ($urandom_range(2) == 0);
      wf = ($urandom_range(60) == 0);
      ws = ($urandom_range(80) == 0);
      r  = ($urandom_range(1500) == 0);
      fd = 28'($urandom);
      sd = ($urandom_range(10) == 0) ? 11'd0 : 11'($urandom_range(30, 1));
      step(hc, wf, fd, ws, sd, r);
    end
    tests++;
    assert (m_dones > 3) else begin
      fails++;
      $error("FAIL slew_done_count: got %0d expected >3", m_dones);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
